// File: rtl/feed_sched_pkg.sv
// Shared types and sizing helpers for the feed scheduler.
// Holds the FSM state enum plus the feed-length and counter-width functions.
package feed_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FEED,
        DRAIN,
        DONE
    } feed_state_t;

    function automatic int feed_len(input int nb, input int nf);
        return nb + nf - 1;
    endfunction

    function automatic int cnt_width(input int nb, input int nf,
                                     input int dc);
        return $clog2(nb + nf + dc) + 1;
    endfunction

endpackage

// File: rtl/feed_scheduler_skew_enable_gen.sv
// Combinational diagonal-skew enable map: feeder i on for i <= cnt < i+N_BYTES.
// Ports: cnt_i (step count), active_i (FEED step valid), en_o (per-feeder enables).
module skew_enable_gen #(
    parameter int N_FEEDERS = 3,
    parameter int N_BYTES   = 7,
    parameter int CW        = 5
) (
    input  logic [CW-1:0]        cnt_i,
    input  logic                 active_i,
    output logic [N_FEEDERS-1:0] en_o
);

    always_comb begin
        en_o = '0;
        for (int i = 0; i < N_FEEDERS; i++) begin
            en_o[i] = active_i
                   && (int'(cnt_i) >= i)
                   && (int'(cnt_i) < i + N_BYTES);
        end
    end

endmodule

// File: rtl/feed_scheduler.sv
// Burst sequencer for the systolic array's data feeders: load, skewed feed, drain, done.
// Ports: clk, reset (sync, active-low), start, ready, busy, load, enable, clear_acc,
// done; hold exists only when FEED_HOLD_EN is defined (stall, freezes the FSM).
module feed_scheduler
    import feed_sched_pkg::*;
#(
    parameter int N_FEEDERS    = 3,
    parameter int N_BYTES      = 7,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
`ifdef FEED_HOLD_EN
    input  logic                 hold,
`endif
    output logic                 ready,
    output logic                 busy,
    output logic [N_FEEDERS-1:0] load,
    output logic [N_FEEDERS-1:0] enable,
    output logic                 clear_acc,
    output logic                 done
);

    localparam int CW = cnt_width(N_BYTES, N_FEEDERS, DRAIN_CYCLES);
    localparam int FL = feed_len(N_BYTES, N_FEEDERS);
    localparam int DL = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam logic [CW-1:0] FEED_LAST  = CW'(FL - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DL);

    logic hold_w;
`ifdef FEED_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    feed_state_t          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ready_d, busy_d, clear_d, done_d, step_d;
    logic [N_FEEDERS-1:0] load_d, enable_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // A stalled cycle keeps the pending step so it replays once hold drops.
        if (hold_w) begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        step_d  = !hold_w;
        ready_d = (state_d == IDLE) && step_d;
        busy_d  = (state_d != IDLE);
        clear_d = (state_d == LOAD) && step_d;
        done_d  = (state_d == DONE) && step_d;
        load_d  = {N_FEEDERS{clear_d}};
    end

    skew_enable_gen #(
        .N_FEEDERS(N_FEEDERS),
        .N_BYTES  (N_BYTES),
        .CW       (CW)
    ) u_skew (
        .cnt_i   (cnt_d),
        .active_i((state_d == FEED) && step_d),
        .en_o    (enable_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            load      <= '0;
            enable    <= '0;
            clear_acc <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready     <= ready_d;
            busy      <= busy_d;
            load      <= load_d;
            enable    <= enable_d;
            clear_acc <= clear_d;
            done      <= done_d;
        end
    end

endmodule
